// File: rtl/majority_vote_pkg.sv
// Shared definitions for the triple-redundant majority voter.
//   state_t        : voter FSM states (IDLE -> VOTE -> HOLD)
//   CNT_W          : width of the per-channel consecutive-mismatch counters
//   THRESH_DEFAULT : default mismatch run length that marks a channel faulty
package majority_vote_pkg;

  typedef enum logic [1:0] {
    IDLE,
    VOTE,
    HOLD
  } state_t;

  localparam int unsigned CNT_W          = 4;
  localparam int unsigned THRESH_DEFAULT = 3;

endpackage

// File: rtl/majority_vote_seq_if.sv
// Request/response bundle of the majority voter.
//   in_valid/in_ready : request handshake carrying channel words y1/y2/y3
//   y/out_valid/out_ready : response handshake carrying the voted word
// master = requester/consumer side, slave = voter side.
interface majority_vote_seq_if #(
  parameter int unsigned W = 8
);

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] y1;
  logic [W-1:0] y2;
  logic [W-1:0] y3;
  logic [W-1:0] y;
  logic         out_valid;
  logic         out_ready;

  modport master (
    output in_valid, y1, y2, y3, out_ready,
    input  in_ready, y, out_valid
  );

  modport slave (
    input  in_valid, y1, y2, y3, out_ready,
    output in_ready, y, out_valid
  );

endinterface

// File: rtl/majority_voter.sv
// Combinational W-bit bitwise 2-of-3 majority.
//   a, b, c : channel words
//   y       : per-bit majority of a, b, c
module majority_voter #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] y
);

  assign y = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/majority_vote_seq.sv
// Sequential triple-redundant voter with per-channel fault tracking.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of majority_vote_seq_if (request in, voted word out)
//   clr_fault  : synchronous pulse clearing fault flags and mismatch counters
//   mismatch   : bit i set when channel i+1 disagreed with the latest vote
//   fault      : sticky per-channel fault flags
//   err        : two or more channels faulty
// A request is captured in IDLE, voted in VOTE and presented in HOLD until
// the consumer accepts it; requests arriving outside IDLE are dropped.
module majority_vote_seq
  import majority_vote_pkg::*;
#(
  parameter int unsigned W      = 8,
  parameter int unsigned THRESH = THRESH_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  majority_vote_seq_if.slave  bus,
  input  logic                clr_fault,
  output logic [2:0]          mismatch,
  output logic [2:0]          fault,
  output logic                err
);

  localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESH);

  state_t           state;
  state_t           state_nxt;
  logic             capture;
  logic             vote_en;
  logic [W-1:0]     c1;
  logic [W-1:0]     c2;
  logic [W-1:0]     c3;
  logic [W-1:0]     vote;
  logic [W-1:0]     y_q;
  logic [2:0]       diff;
  logic [CNT_W-1:0] cnt     [3];
  logic [CNT_W-1:0] cnt_nxt [3];
  logic [2:0]       fault_nxt;

  majority_voter #(.W(W)) u_voter (
    .a (c1),
    .b (c2),
    .c (c3),
    .y (vote)
  );

  assign diff = {c3 != vote, c2 != vote, c1 != vote};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    capture       = 1'b0;
    vote_en       = 1'b0;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          capture   = 1'b1;
          state_nxt = VOTE;
        end
      end
      VOTE: begin
        vote_en   = 1'b1;
        state_nxt = HOLD;
      end
      HOLD: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Clear takes priority over a coincident vote; mismatch is still updated
  // by the vote because it lives in the datapath register below.
  always_comb begin
    fault_nxt = fault;
    for (int unsigned i = 0; i < 3; i++) begin
      cnt_nxt[i] = cnt[i];
      if (clr_fault) begin
        cnt_nxt[i]   = '0;
        fault_nxt[i] = 1'b0;
      end else if (vote_en) begin
        if (!diff[i])                cnt_nxt[i] = '0;
        else if (cnt[i] < THRESH_C)  cnt_nxt[i] = cnt[i] + CNT_W'(1);
        if (cnt_nxt[i] == THRESH_C)  fault_nxt[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c1       <= '0;
      c2       <= '0;
      c3       <= '0;
      y_q      <= '0;
      mismatch <= '0;
      fault    <= '0;
      for (int unsigned i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      if (capture) begin
        c1 <= bus.y1;
        c2 <= bus.y2;
        c3 <= bus.y3;
      end
      if (vote_en) begin
        y_q      <= vote;
        mismatch <= diff;
      end
      fault <= fault_nxt;
      for (int unsigned i = 0; i < 3; i++) cnt[i] <= cnt_nxt[i];
    end
  end

  assign bus.y = y_q;
  assign err   = (fault[0] & fault[1]) | (fault[0] & fault[2]) | (fault[1] & fault[2]);

endmodule

// File: tb/tb_majority_vote_seq.sv
module tb_majority_vote_seq;

  localparam int unsigned W  = 8;
  localparam int unsigned TH = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr_fault = 1'b0;
  logic [2:0] mismatch;
  logic [2:0] fault;
  logic       err;

  majority_vote_seq_if #(.W(W)) bus ();

  majority_vote_seq #(.W(W), .THRESH(TH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .clr_fault (clr_fault),
    .mismatch  (mismatch),
    .fault     (fault),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] y;
    logic [2:0] mm;
    logic [2:0] flt;
  } exp_t;

  exp_t       sb[$];
  int         m_cnt[3];
  logic [2:0] m_flt;
  logic [7:0] last_y;
  int         n_vec = 0;
  int         n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] maj(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      int s;
      s = int'(a[i]) + int'(b[i]) + int'(c[i]);
      r[i] = (s >= 2);
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 3; i++) m_cnt[i] = 0;
    m_flt = 3'b000;
  endtask

  task automatic push_expected(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input bit clr);
    exp_t       e;
    logic [7:0] m;
    logic [7:0] ch[3];
    m = maj(a, b, c);
    ch[0] = a; ch[1] = b; ch[2] = c;
    for (int i = 0; i < 3; i++) begin
      e.mm[i] = (ch[i] != m);
      if (clr) begin
        m_cnt[i] = 0;
        m_flt[i] = 1'b0;
      end else if (e.mm[i]) begin
        if (m_cnt[i] < TH) m_cnt[i]++;
        if (m_cnt[i] == TH) m_flt[i] = 1'b1;
      end else begin
        m_cnt[i] = 0;
      end
    end
    e.y   = m;
    e.flt = m_flt;
    sb.push_back(e);
  endtask

  // Wait (bounded) for a response, compare against the oldest expectation,
  // and if the consumer is ready confirm the return to IDLE.
  task automatic drain(input int budget);
    int   waited = 0;
    exp_t e;
    while (!bus.out_valid && waited < budget) begin
      tick();
      waited++;
    end
    if (!bus.out_valid) begin
      chk("out_timeout", 32'(bus.out_valid), 32'd1);
      return;
    end
    chk("latency", 32'(waited), 32'd0);
    if (sb.size() == 0) begin
      chk("sb_underflow", 32'(sb.size()), 32'd1);
      return;
    end
    e = sb.pop_front();
    last_y = e.y;
    chk("y", 32'(bus.y), 32'(e.y));
    chk("mismatch", 32'(mismatch), 32'(e.mm));
    chk("fault", 32'(fault), 32'(e.flt));
    chk("err", 32'(err), 32'($countones(e.flt) >= 2));
    if (bus.out_ready) begin
      tick();
      chk("ovalid_1cyc", 32'(bus.out_valid), 32'd0);
      chk("ready_again", 32'(bus.in_ready), 32'd1);
    end
  endtask

  task automatic txn(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input bit clr);
    bus.y1 = a; bus.y2 = b; bus.y3 = c;
    bus.in_valid = 1'b1;
    chk("accept_ready", 32'(bus.in_ready), 32'd1);
    push_expected(a, b, c, clr);
    tick();
    bus.in_valid = 1'b0;
    clr_fault = clr;
    chk("vote_ovalid", 32'(bus.out_valid), 32'd0);
    chk("vote_iready", 32'(bus.in_ready), 32'd0);
    tick();
    clr_fault = 1'b0;
    drain(8);
  endtask

  task automatic clear_pulse();
    clr_fault = 1'b1;
    tick();
    clr_fault = 1'b0;
    model_clear();
    chk("clr_fault", 32'(fault), 32'd0);
    chk("clr_err", 32'(err), 32'd0);
    chk("clr_y", 32'(bus.y), 32'(last_y));
    chk("clr_ovalid", 32'(bus.out_valid), 32'd0);
    chk("clr_iready", 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.y1        = '0;
    bus.y2        = '0;
    bus.y3        = '0;
    bus.out_ready = 1'b1;
    model_clear();
    last_y = '0;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_y", 32'(bus.y), 32'd0);
    chk("rst_ovalid", 32'(bus.out_valid), 32'd0);
    chk("rst_mismatch", 32'(mismatch), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    chk("rel_iready", 32'(bus.in_ready), 32'd1);

    // Single outlier channel, then all three channels disagreeing
    txn(8'h00, 8'h00, 8'hFF, 1'b0);
    txn(8'hF0, 8'h3C, 8'h0F, 1'b0);
    clear_pulse();

    // Channel 3 wrong three times in a row -> faulty; matching vote keeps it sticky
    repeat (3) txn(8'hAA, 8'hAA, 8'h55, 1'b0);
    txn(8'hAA, 8'hAA, 8'hAA, 1'b0);

    // Channel 1 faulty as well -> err
    repeat (3) txn(8'h55, 8'hAA, 8'hAA, 1'b0);
    clear_pulse();

    // Clear coincident with the third failing vote on channel 1
    repeat (2) txn(8'h11, 8'h22, 8'h22, 1'b0);
    txn(8'h11, 8'h22, 8'h22, 1'b1);
    repeat (2) txn(8'h11, 8'h22, 8'h22, 1'b0);
    txn(8'h11, 8'h22, 8'h22, 1'b0);

    // Back-pressure in HOLD with a request pulsed meanwhile
    bus.out_ready = 1'b0;
    bus.y1 = 8'h12; bus.y2 = 8'h12; bus.y3 = 8'h34;
    bus.in_valid = 1'b1;
    push_expected(8'h12, 8'h12, 8'h34, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("hold_ovalid", 32'(bus.out_valid), 32'd1);
      chk("hold_iready", 32'(bus.in_ready), 32'd0);
      chk("hold_y", 32'(bus.y), 32'h12);
      if (k == 1) begin
        bus.y1 = 8'hFF; bus.y2 = 8'hFF; bus.y3 = 8'hFF;
        bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      tick();
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    drain(2);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("dropped_req", 32'(bus.out_valid), 32'd0);
    end

    // Reset during HOLD aborts the transaction
    bus.y1 = 8'h00; bus.y2 = 8'hFF; bus.y3 = 8'hFF;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    chk("pre_rst_ovalid", 32'(bus.out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    model_clear();
    chk("arst_y", 32'(bus.y), 32'd0);
    chk("arst_ovalid", 32'(bus.out_valid), 32'd0);
    chk("arst_mismatch", 32'(mismatch), 32'd0);
    chk("arst_fault", 32'(fault), 32'd0);
    chk("arst_err", 32'(err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("arel_iready", 32'(bus.in_ready), 32'd1);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("no_stale_ovalid", 32'(bus.out_valid), 32'd0);
    end
    last_y = '0;

    // Counters restart from zero after reset
    repeat (2) txn(8'h11, 8'h22, 8'h22, 1'b0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
